// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int OP_W     = 3;
    localparam int REQ_FILT = 0;
    localparam int REQ_RATE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (req_valid_i)
            2'b01:   grant_o[REQ_FILT] = 1'b1;
            2'b10:   grant_o[REQ_RATE] = 1'b1;
            2'b11: begin
                if (last_grant_i) grant_o[REQ_FILT] = 1'b1;
                else              grant_o[REQ_RATE] = 1'b1;
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the sample filter and the rate calculator.
// Define ALU_ARB_STATS_EN to add the saturating per-requester grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q;
    logic             owner_q, owner_d;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [1:0]       grant;
    logic             accept;

    alu_arb_rr u_rr (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign accept  = (state_q == IDLE) && (|req_valid);
    assign owner_d = grant[REQ_RATE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the owner's resp_ready is honoured; the other bit is don't-care.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = grant;
            EXEC:    busy = 1'b1;
            RESP: begin
                busy                = 1'b1;
                resp_valid[owner_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand registers are loaded only on accept, so the ALU inputs hold between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= owner_d;
                owner_q      <= owner_d;
                op_q         <= owner_d ? req_op1 : req_op0;
                a_q          <= owner_d ? req_a1  : req_a0;
                b_q          <= owner_d ? req_b1  : req_b0;
            end
            if (state_q == EXEC) result_q <= alu_result;
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign resp_data = result_q;

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (grant[REQ_FILT] && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (grant[REQ_RATE] && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int STAT_W = 4;
    localparam int CMAX   = (1 << STAT_W) - 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
    logic [2:0]       req_op0, req_op1, alu_op;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [WIDTH-1:0] resp_data, alu_a, alu_b, alu_result;
    logic             busy;
`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(
        .WIDTH (WIDTH)
`ifdef ALU_ARB_STATS_EN
        , .STAT_W (STAT_W)
`endif
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_op0 (req_op0), .req_a0 (req_a0), .req_b0 (req_b0),
        .req_op1 (req_op1), .req_a1 (req_a1), .req_b1 (req_b1),
        .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_data (resp_data),
        .alu_op (alu_op), .alu_a (alu_a), .alu_b (alu_b), .alu_result (alu_result),
        .busy (busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0 (grant_cnt0), .grant_cnt1 (grant_cnt1)
`endif
    );

    // Bench-side ALU: an arbitrary but fully defined function of all 8 opcodes.
    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: one op in flight, m_age counts cycles since its accept.
    bit               m_fly;
    int               m_age, m_owner, m_last, m_acc0, m_acc1;
    logic [2:0]       m_op;
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic [1:0]       m_ready;
    bit               rnd;
    bit               pend [2];
    int               grants [$];

    function automatic logic [1:0] winner(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_reset();
        m_fly = 0; m_age = 0; m_owner = 0; m_last = 1;
        m_acc0 = 0; m_acc1 = 0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0;
        pend[0] = 0; pend[1] = 0;
    endtask

    task automatic settle();
        logic [1:0] ev;
        if (rnd) begin
            if (!pend[0] && $urandom_range(0, 2) == 0) begin
                pend[0] = 1; req_op0 = 3'($urandom); req_a0 = $urandom; req_b0 = $urandom;
            end
            if (!pend[1] && $urandom_range(0, 2) == 0) begin
                pend[1] = 1; req_op1 = 3'($urandom); req_a1 = $urandom; req_b1 = $urandom;
            end
            req_valid  = {pend[1], pend[0]};
            resp_ready = 2'($urandom_range(0, 3));
        end
        #1;
        m_ready = m_fly ? 2'b00 : winner(req_valid, m_last);
        ev = 2'b00;
        if (m_fly && m_age >= 2) ev[m_owner] = 1'b1;
        chk("req_ready",  req_ready, m_ready);
        chk("busy",       busy, m_fly);
        chk("resp_valid", resp_valid, ev);
        if (m_fly && m_age >= 2) chk("resp_data", resp_data, m_res);
        chk("alu_op", alu_op, m_op);
        chk("alu_a",  alu_a,  m_a);
        chk("alu_b",  alu_b,  m_b);
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", grant_cnt0, (m_acc0 > CMAX) ? CMAX : m_acc0);
        chk("grant_cnt1", grant_cnt1, (m_acc1 > CMAX) ? CMAX : m_acc1);
`endif
    endtask

    task automatic tick();
        logic [1:0] rr_seen;
        logic [1:0] rdy_seen;
        rr_seen  = resp_ready;
        rdy_seen = m_ready;
        @(posedge clk);
        if (!m_fly) begin
            if (rdy_seen != 2'b00) begin
                m_owner = rdy_seen[1] ? 1 : 0;
                m_op  = m_owner ? req_op1 : req_op0;
                m_a   = m_owner ? req_a1  : req_a0;
                m_b   = m_owner ? req_b1  : req_b0;
                m_res = alu_f(m_op, m_a, m_b);
                m_last = m_owner;
                if (m_owner == 1) m_acc1++; else m_acc0++;
                grants.push_back(m_owner);
                if (rnd) pend[m_owner] = 0;
                m_fly = 1; m_age = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rr_seen[m_owner]) begin
            m_fly = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready",  req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_data",  resp_data, 0);
        chk("rst_alu_op",     alu_op, 0);
        chk("rst_alu_a",      alu_a, 0);
        chk("rst_alu_b",      alu_b, 0);
        chk("rst_busy",       busy, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (4) begin settle(); tick(); end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        rnd = 0;
        req_valid = 2'b00; resp_ready = 2'b00;
        req_op0 = '0; req_a0 = '0; req_b0 = '0;
        req_op1 = '0; req_a1 = '0; req_b1 = '0;
        model_reset();
        do_reset();

        // Single op: 5 + 3 from requester 0
        req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 5; req_b0 = 3; resp_ready = 2'b01;
        settle(); chk("single_ready", req_ready, 2'b01); tick();
        req_valid = 2'b00;
        settle(); chk("single_alu_op", alu_op, 0); chk("single_alu_a", alu_a, 5);
        chk("single_alu_b", alu_b, 3); tick();
        settle(); chk("single_resp_valid", resp_valid, 2'b01); chk("single_resp_data", resp_data, 8);
        tick();
        settle(); chk("single_idle", busy, 1'b0); tick();

        // Tie from reset: strict alternation starting with requester 0
        do_reset();
        grants.delete();
        req_valid = 2'b11; resp_ready = 2'b11;
        req_op0 = 3'd1; req_a0 = 100; req_b0 = 7;
        req_op1 = 3'd4; req_a1 = 32'hF0F0; req_b1 = 32'h0FF0;
        repeat (12) begin settle(); tick(); end
        chk("tie_count", grants.size(), 4);
        foreach (grants[k]) chk("tie_seq", grants[k], k % 2);
        drain();

        // Back-pressure: response held for 10 cycles, no acceptance meanwhile
        req_valid = 2'b01; req_op0 = 3'd5; req_a0 = 32'h3; req_b0 = 32'd4; resp_ready = 2'b00;
        settle(); tick();
        req_valid = 2'b11;
        settle(); tick();
        settle(); held = resp_data; chk("bp_data", held, 32'h30); tick();
        repeat (10) begin
            settle();
            chk("bp_hold", resp_data, held);
            chk("bp_no_accept", req_ready, 2'b00);
            tick();
        end
        resp_ready = 2'b10;
        settle(); chk("bp_other_ignored", resp_valid, 2'b01); tick();
        req_valid = 2'b00; resp_ready = 2'b01;
        settle(); tick();
        settle(); chk("bp_idle", busy, 1'b0); tick();

        // Busy rejection: requester 1 rises one cycle after an accept
        req_valid = 2'b01; req_op0 = 3'd7; req_a0 = 2; req_b0 = 9; resp_ready = 2'b11;
        settle(); tick();
        req_valid = 2'b11; req_op1 = 3'd3; req_a1 = 32'h10; req_b1 = 32'h01;
        settle(); chk("busy_rej_n1", req_ready[1], 1'b0); tick();
        settle(); chk("busy_rej_n2", req_ready[1], 1'b0); tick();
        settle(); chk("busy_acc_n3", req_ready, 2'b10); tick();
        drain();

        // Reset during EXEC drops the op; a tie afterwards goes to requester 0
        req_valid = 2'b10; req_op1 = 3'd2; req_a1 = 32'hFF; req_b1 = 32'h0F; resp_ready = 2'b11;
        settle(); tick();
        chk("mid_in_exec", busy, 1'b1);
        do_reset();
        req_valid = 2'b11;
        settle(); chk("mid_rst_tie", req_ready, 2'b01); tick();
        drain();

`ifdef ALU_ARB_STATS_EN
        // 17 accepts from requester 1 saturate a 4-bit counter
        do_reset();
        req_valid = 2'b10; resp_ready = 2'b11;
        repeat (17) begin
            req_a1 = $urandom; req_b1 = $urandom; req_op1 = 3'($urandom);
            repeat (3) begin settle(); tick(); end
        end
        req_valid = 2'b00;
        settle();
        chk("stats_cnt1", grant_cnt1, 15);
        chk("stats_cnt0", grant_cnt0, 0);
        tick();
`endif

        // Random traffic with random back-pressure
        do_reset();
        rnd = 1;
        repeat (3000) begin settle(); tick(); end
        rnd = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (opcode decoder plus datapath) between two requesters, the sample-filter engine (requester 0) and the heart-rate calculator (requester 1). The block arbitrates round-robin and registers the winning opcode and operands into the ALU for one execute cycle. It captures the result and returns it to the winner over a valid/ready response handshake. It sits between both requesters and the ALU and is the only driver of the ALU's opcode and operand inputs.

## Interface
- WIDTH, 32, operand/result width
- STAT_W, 16, width of grant counters (only with ALU_ARB_STATS_EN)

- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: operation of requester i accepted this cycle
- req_op0 / req_op1  in  3  3-bit ALU opcode of requester 0 / 1
- req_a0, req_b0 / req_a1, req_b1  in  WIDTH  operands of requester 0 / 1
- resp_valid  out  2  bit i: result for requester i available
- resp_ready  in  2  bit i: requester i takes result
- resp_data  out  WIDTH  result, shared bus, meaningful only while a resp_valid bit is high
- alu_op  out  3  opcode to ALU decoder
- alu_a, alu_b  out  WIDTH  operands to ALU datapath
- alu_result  in  WIDTH  combinational ALU result
- busy  out  1  high in EXEC or RESP
- grant_cnt0 / grant_cnt1  out  STAT_W  accepted-operation counts (only with ALU_ARB_STATS_EN)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is high, pick a winner. A single requester wins outright. With both requesting, the winner is the requester other than last_grant. Assert req_ready for the winner only, same cycle, combinationally from req_valid and last_grant. Latch op, a, b and owner; last_grant <= owner. Go to EXEC.
- EXEC: drive alu_op, alu_a and alu_b from the latched registers. Capture alu_result into the result register at the cycle's end. Go to RESP.
- RESP: resp_valid[owner]=1, resp_data = result register. On resp_ready[owner], go to IDLE. The other resp_ready bit is ignored.
- Outside EXEC, alu_op, alu_a and alu_b hold their last latched values. They are all-zero after reset.
- Opcodes pass through unmodified. All 8 encodings are legal, and the arbiter interprets none of them.
- Requesters hold req_valid and their operands stable until req_ready. The arbiter does not check this.
- Reset values: req_ready=0, resp_valid=0, resp_data=0, alu_op=0, alu_a=0, alu_b=0, busy=0, state=IDLE, last_grant=1 (requester 0 wins the first tie), counters=0.

## Timing
- Cycle N: accept (req_ready high).
- Cycle N+1: EXEC, ALU inputs valid.
- Cycle N+2: resp_valid high. Accept-to-response latency is exactly 2 cycles.
- resp_valid and resp_data stay stable until resp_ready. Back-pressure is unbounded.
- If resp_ready is already high at N+2, FSM is IDLE at N+3. Next accept is possible at N+3, so peak throughput is 1 op per 3 cycles.
- No acceptance in EXEC or RESP; req_ready=0 there regardless of req_valid.
- Requests pending in both slots at the same IDLE cycle alternate strictly. A requester asserting alone wins every time, and last_grant still updates.
- Asynchronous reset in any state clears all outputs immediately and discards the in-flight operation; no response is produced for it.

## Configuration
- ALU_ARB_STATS_EN defined: grant_cnt0/1 present. Each increments on its requester's accept and saturates at all-ones.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package alu_arb_pkg: state enum (IDLE, EXEC, RESP), opcode width constant 3, requester index constants REQ_FILT=0, REQ_RATE=1.
- Sub-module alu_arb_rr: 2-way round-robin pick (inputs req_valid and last_grant; outputs grant one-hot), purely combinational.
- Top holds the FSM, operand/result registers and optional counters.

## Test plan
- Single op: at N, req_valid=01, op0=000, a0=5, b0=3, bench ALU model adds -> req_ready=01 at N; alu_op=000, alu_a=5, alu_b=3 at N+1; resp_valid=01, resp_data=8 at N+2.
- Tie: req_valid=11 held from reset -> grants go 0,1,0,1 on successive accepts. resp_valid alternates 01/10.
- Back-pressure: resp_ready=00 for 10 cycles after N+2 -> resp_valid and resp_data are held constant, req_ready stays 00, busy=1; resp_ready=01 -> IDLE next cycle.
- Busy rejection: req_valid[1] rises at N+1 -> req_ready[1]=0 until IDLE, then accepted at N+3 with resp_ready high at N+2.
- Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately. After release, there is no resp_valid for the dropped op, and a tie grants requester 0.
- Stats (ALU_ARB_STATS_EN, STAT_W=4): 17 accepts from requester 1 -> grant_cnt1=15, grant_cnt0=0.
